// File: rtl/up_dn_driver_if.sv
// Handshake bundle between the up/down driver and whoever owns the counter.
// The master side issues Start/Mode/Target and feeds back the counter state.
interface up_dn_driver_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] counter_in;
    logic             high_in;
    logic             low_in;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up;
    logic             down;
    logic             busy;
    logic             done;
    logic             err;
    logic [5:0]       steps;

    // Start is a level sampled only while busy is low. It is not a valid/ready pair.
    // load/up/down are one-cycle command pulses, and at most one is high in any cycle.
    // done/err are one-cycle pulses that end a move.
    modport master (
        output start, mode, target, counter_in, high_in, low_in,
        input  load, load_val, up, down, busy, done, err, steps
    );

    modport slave (
        input  start, mode, target, counter_in, high_in, low_in,
        output load, load_val, up, down, busy, done, err, steps
    );
endinterface

// File: rtl/up_dn_driver.sv
// Drives an external up/down counter to a latched target value.
// The counter is either loaded directly or stepped one Up/Down pulse at a time, bounded by MAX_STEPS.
module up_dn_driver #(
    parameter int WIDTH     = 5,
    parameter int MAX_STEPS = 40
) (
    input  logic           i_clk,
    input  logic           i_rst,
    up_dn_driver_if.slave  bus,
    output logic [2:0]     o_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [5:0] MAX_S = 6'(MAX_STEPS);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_target;
    logic [5:0]       r_steps;
    logic             r_load;
    logic             r_up;
    logic             r_down;
    logic             w_accept;
    logic             w_need_up;
    logic             w_need_dn;
    logic             w_issue_up;
    logic             w_issue_dn;

    assign w_accept  = (r_state == S_IDLE) && bus.start;
    assign w_need_up = r_target > bus.counter_in;
    assign w_need_dn = r_target < bus.counter_in;

    // Direction is resolved in CHECK from the live counter value, so an external disturbance is picked up on the next step.
    always_comb begin
        w_next     = r_state;
        w_issue_up = 1'b0;
        w_issue_dn = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = bus.mode ? S_LOAD : S_CHECK;
                end
            end
            S_LOAD:  w_next = S_CHECK;
            S_CHECK: begin
                if (bus.counter_in == r_target) begin
                    w_next = S_DONE;
                end else if (r_steps == MAX_S) begin
                    w_next = S_ERR;
                end else if ((w_need_up && bus.high_in) || (w_need_dn && bus.low_in)) begin
                    w_next = S_ERR;
                end else begin
                    w_next     = S_ISSUE;
                    w_issue_up = w_need_up;
                    w_issue_dn = w_need_dn;
                end
            end
            S_ISSUE: w_next = S_CHECK;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_target <= '0;
            r_steps  <= '0;
            r_load   <= 1'b0;
            r_up     <= 1'b0;
            r_down   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_load  <= w_accept && bus.mode;
            r_up    <= w_issue_up;
            r_down  <= w_issue_dn;
            if (w_accept) begin
                r_target <= bus.target;
                r_steps  <= '0;
            end else if (w_issue_up || w_issue_dn) begin
                // The count is bumped together with the pulse, so Steps already includes it while Up/Down is high.
                r_steps <= r_steps + 6'd1;
            end
        end
    end

    assign bus.load     = r_load;
    assign bus.load_val = r_target;
    assign bus.up       = r_up;
    assign bus.down     = r_down;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.err      = (r_state == S_ERR);
    assign bus.steps    = r_steps;
    assign o_state      = r_state;
endmodule

// File: tb/tb_up_dn_driver.sv
// Bench for up_dn_driver: a behavioural counter closes the loop on the main instance.
// A second instance with MAX_STEPS=4 exercises the step-limit error.
module tb_up_dn_driver;
    localparam int WIDTH = 5;
    localparam int W     = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    up_dn_driver_if #(.WIDTH(WIDTH)) ifa ();
    up_dn_driver_if #(.WIDTH(WIDTH)) ifb ();
    logic [2:0] st_a;
    logic [2:0] st_b;

    up_dn_driver #(.WIDTH(WIDTH)) dut (
        .i_clk(clk), .i_rst(rst), .bus(ifa.slave), .o_state(st_a)
    );
    up_dn_driver #(.WIDTH(WIDTH), .MAX_STEPS(4)) dut_lim (
        .i_clk(clk), .i_rst(rst), .bus(ifb.slave), .o_state(st_b)
    );

    // Behavioural counter that follows the main instance's commands.
    logic [4:0] cnt;
    logic       preset_en;
    logic [4:0] preset_val;
    logic       ovr;
    logic [4:0] ovr_val;
    logic       ovr_high;

    always @(posedge clk) begin
        if (preset_en)                        cnt <= preset_val;
        else if (ifa.load)                    cnt <= ifa.load_val;
        else if (ifa.up && cnt != 5'd31)      cnt <= cnt + 5'd1;
        else if (ifa.down && cnt != 5'd0)     cnt <= cnt - 5'd1;
    end

    assign ifa.counter_in = ovr ? ovr_val : cnt;
    assign ifa.high_in    = ovr ? ovr_high : (cnt == 5'd31);
    assign ifa.low_in     = ovr ? 1'b0 : (cnt == 5'd0);

    // The limited instance watches a counter stuck at zero.
    assign ifb.counter_in = '0;
    assign ifb.high_in    = 1'b0;
    assign ifb.low_in     = 1'b1;

    int n_up, n_dn, n_ld, nb_up, nb_done, viol;
    initial begin
        n_up = 0; n_dn = 0; n_ld = 0; nb_up = 0; nb_done = 0; viol = 0;
    end
    always @(negedge clk) begin
        if (ifa.up)   n_up++;
        if (ifa.down) n_dn++;
        if (ifa.load) n_ld++;
        if (ifb.up)   nb_up++;
        if (ifb.done) nb_done++;
        if ((int'(ifa.up) + int'(ifa.down) + int'(ifa.load)) > 1) viol++;
        if (!ifa.busy && (ifa.up || ifa.down || ifa.load)) viol++;
        if ((int'(ifb.up) + int'(ifb.down) + int'(ifb.load)) > 1) viol++;
    end

    // Scoreboard: {kind[15:14], steps[13:8], latency[7:0]}, kind 1 = done, 2 = err.
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic preset(input logic [4:0] v);
        preset_en  = 1'b1;
        preset_val = v;
        @(posedge clk); #1;
        preset_en  = 1'b0;
    endtask

    task automatic do_move(input string tag, input logic m, input logic [4:0] tgt, input bit drop,
                           input int ek, input int es, input int el,
                           input int eu, input int ed, input int eld);
        int up0 = n_up;
        int dn0 = n_dn;
        int ld0 = n_ld;
        int lat = 0;
        bit seen = 1'b0;
        logic [1:0] kind;
        logic [W-1:0] e;
        exp_q.push_back({2'(ek), 6'(es), 8'(el)});
        ifa.start  = 1'b1;
        ifa.mode   = m;
        ifa.target = tgt;
        @(posedge clk); #1;
        // Start stays high into the busy period, and Mode/Target are scrambled; none of this may disturb the move.
        ifa.target = ~tgt;
        ifa.mode   = ~m;
        if (drop) ovr_val = ovr_val - 5'd1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check_val({tag, "_busy"}, 32'(ifa.busy), 1);
            if (lat == 2) ifa.start = 1'b0;
            if (ifa.done || ifa.err) begin
                seen = 1'b1;
                break;
            end
        end
        ifa.start = 1'b0;
        check_val({tag, "_timeout"}, 32'(seen), 1);
        kind = ifa.err ? 2'd2 : (ifa.done ? 2'd1 : 2'd0);
        e = exp_q.pop_front();
        check_val({tag, "_kind"},    32'(kind),       32'(e[15:14]));
        check_val({tag, "_steps"},   32'(ifa.steps),  32'(e[13:8]));
        check_val({tag, "_latency"}, 32'(lat),        32'(e[7:0]));
        check_val({tag, "_ups"},     32'(n_up - up0), 32'(eu));
        check_val({tag, "_downs"},   32'(n_dn - dn0), 32'(ed));
        check_val({tag, "_loads"},   32'(n_ld - ld0), 32'(eld));
        check_val({tag, "_load_val"}, 32'(ifa.load_val), 32'(tgt));
        @(posedge clk); #1;
        check_val({tag, "_idle"}, 32'(ifa.busy), 0);
    endtask

    initial begin
        int s, t, d, lat, hits;
        logic [W-1:0] e;
        bit seen;
        rst = 1'b1;
        ifa.start = 1'b1; ifa.mode = 1'b0; ifa.target = 5'd17;
        ifb.start = 1'b0; ifb.mode = 1'b0; ifb.target = 5'd10;
        preset_en = 1'b0; preset_val = '0; ovr = 1'b0; ovr_val = '0; ovr_high = 1'b0;
        // Start is held high alongside reset, and reset must win.
        repeat (2) @(posedge clk); #1;
        check_val("rst_busy",     32'(ifa.busy), 0);
        check_val("rst_cmds",     32'({ifa.load, ifa.up, ifa.down}), 0);
        check_val("rst_done_err", 32'({ifa.done, ifa.err}), 0);
        check_val("rst_steps",    32'(ifa.steps), 0);
        check_val("rst_load_val", 32'(ifa.load_val), 0);
        ifa.start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        preset(5'd3);  do_move("up_3_7",   1'b0, 5'd7,  1'b0, 1, 4, 10, 4, 0, 0);
        preset(5'd20); do_move("load_20_5", 1'b1, 5'd5, 1'b0, 1, 0, 3,  0, 0, 1);
        preset(5'd9);  do_move("zero_9",   1'b0, 5'd9,  1'b0, 1, 0, 2,  0, 0, 0);
        preset(5'd12); do_move("down_12_9", 1'b0, 5'd9, 1'b0, 1, 3, 8,  0, 3, 0);
        preset(5'd0);  do_move("full_0_31", 1'b0, 5'd31, 1'b0, 1, 31, 64, 31, 0, 0);

        // Counter pinned at maximum while the target is above it.
        ovr = 1'b1; ovr_val = 5'd31; ovr_high = 1'b1;
        do_move("high_block", 1'b0, 5'd31, 1'b1, 2, 0, 2, 0, 0, 0);
        ovr = 1'b0;

        // Reset lands during the third ISSUE of a 0->8 move.
        preset(5'd0);
        ifa.start = 1'b1; ifa.mode = 1'b0; ifa.target = 5'd8;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        repeat (5) @(posedge clk); #1;
        check_val("abort_third_up", 32'(ifa.up), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_busy",  32'(ifa.busy), 0);
        check_val("abort_cmds",  32'({ifa.load, ifa.up, ifa.down}), 0);
        check_val("abort_steps", 32'(ifa.steps), 0);
        hits = 0;
        repeat (5) begin
            @(negedge clk);
            if (ifa.done || ifa.err) hits++;
        end
        check_val("abort_no_pulse", 32'(hits), 0);
        @(posedge clk); #1;
        do_move("after_abort", 1'b0, 5'd8, 1'b0, 1, 5, 12, 5, 0, 0);

        for (int i = 0; i < 4; i++) begin
            s = $urandom_range(0, 31);
            t = $urandom_range(0, 31);
            d = (s > t) ? s - t : t - s;
            preset(5'(s));
            do_move("rand_step", 1'b0, 5'(t), 1'b0, 1, d, 2 * d + 2,
                    (t > s) ? d : 0, (t < s) ? d : 0, 0);
            s = $urandom_range(0, 31);
            t = $urandom_range(0, 31);
            preset(5'(s));
            do_move("rand_load", 1'b1, 5'(t), 1'b0, 1, 0, 3, 0, 0, 1);
        end

        // Step limit on the MAX_STEPS=4 instance with a counter that never moves.
        exp_q.push_back({2'd2, 6'd4, 8'd10});
        ifb.start = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        lat = 0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            lat++;
            if (ifb.done || ifb.err) begin
                seen = 1'b1;
                break;
            end
        end
        e = exp_q.pop_front();
        check_val("limit_timeout", 32'(seen), 1);
        check_val("limit_kind",    32'(ifb.err ? 2'd2 : (ifb.done ? 2'd1 : 2'd0)), 32'(e[15:14]));
        check_val("limit_steps",   32'(ifb.steps), 32'(e[13:8]));
        check_val("limit_latency", 32'(lat), 32'(e[7:0]));
        check_val("limit_ups",     32'(nb_up), 4);
        repeat (3) @(posedge clk); #1;
        check_val("limit_no_done", 32'(nb_done), 0);
        check_val("limit_steps_hold", 32'(ifb.steps), 4);

        check_val("cmd_exclusive", 32'(viol), 0);
        check_val("queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/up_dn_driver.md
UP_DN_DRIVER -- requirements
Module: up_dn_driver

Interface
REQ-001 Parameter WIDTH, default 5, counter/target width in bits.
REQ-002 Parameter MAX_STEPS, default 40, maximum Up/Down pulses per move before error (range 1..63).
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  begin move; sampled only in IDLE.
REQ-006 Mode  input  1  0 = step toward target, 1 = direct load; sampled with Start.
REQ-007 Target  input  WIDTH  destination value; latched on accepted Start.
REQ-008 Counter_In  input  WIDTH  counter value fed back from the driven up/down counter.
REQ-009 High_In  input  1  counter-at-maximum flag fed back.
REQ-010 Low_In  input  1  counter-at-zero flag fed back.
REQ-011 Load  output  1  counter load command, registered.
REQ-012 Load_Val  output  WIDTH  value to load, registered; equals latched target.
REQ-013 Up  output  1  increment command, registered.
REQ-014 Down  output  1  decrement command, registered.
REQ-015 Busy  output  1  high in every state except IDLE.
REQ-016 Done  output  1  one-cycle pulse on successful move.
REQ-017 Err  output  1  one-cycle pulse on failed move.
REQ-018 Steps  output  6  pulses issued in current/last move; holds until next accepted Start.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, CHECK, ISSUE, DONE, ERR.
REQ-020 IDLE: Start=1 latches Target, clears Steps, goes LOAD if Mode=1 else CHECK.
REQ-021 LOAD: Load=1 for exactly one cycle with Load_Val=latched target; next state CHECK.
REQ-022 CHECK: no command asserted; Counter_In==target -> DONE; else Steps==MAX_STEPS -> ERR; else need-up with High_In=1 or need-down with Low_In=1 -> ERR; else ISSUE.
REQ-023 ISSUE: exactly one of Up (target>Counter_In, unsigned) or Down (target<Counter_In) high for one cycle, direction decided in preceding CHECK; Steps increments by 1; next state CHECK.
REQ-024 DONE: Done=1 one cycle; next IDLE. ERR: Err=1 one cycle; next IDLE.
REQ-025 Load, Up, Down SHALL be mutually exclusive and never high outside LOAD/ISSUE.
REQ-026 Step-mode latency: distance d -> Done high in the (2d+2)th cycle after the Start edge; d=0 -> Done in cycle 2, Steps=0.
REQ-027 Load-mode latency: Done in cycle 3 after Start edge if counter takes the load; Steps=0.
REQ-028 Start while Busy SHALL be ignored; latched target and Mode unchanged.
REQ-029 Counter_In change by external source mid-move SHALL be tolerated: each CHECK re-evaluates direction.
REQ-030 Steps SHALL never exceed MAX_STEPS; no wrap.
REQ-031 Target changes after acceptance SHALL have no effect on the move in progress.

Reset
REQ-032 RST=1 at any edge forces IDLE; Load, Up, Down, Busy, Done, Err = 0; Steps = 0; Load_Val = 0; latched target = 0.
REQ-033 Reset mid-move SHALL abort with no Done or Err pulse; command outputs low the cycle after the reset edge.
REQ-034 RST has priority over Start on the same edge.

Verification
REQ-035 Counter_In=3, Start, Mode=0, Target=7 -> four Up pulses each separated by one idle cycle, Done in cycle 10, Steps=4.
REQ-036 Counter_In=20, Start, Mode=1, Target=5 -> Load one cycle with Load_Val=5, Done in cycle 3, Steps=0, Up/Down never high.
REQ-037 Counter_In=9, Start, Mode=0, Target=9 -> no commands, Done in cycle 2, Steps=0.
REQ-038 Counter_In held at 0 (counter ignores Up), Target=10, MAX_STEPS=4 -> four Up pulses, Err pulse, Done never high, Steps=4.
REQ-039 Counter_In=31, High_In=1, external source forces target-above scenario (Target latched 31, Counter_In dropped to 30 then High_In held 1) -> ERR without issuing Up.
REQ-040 RST asserted during third ISSUE of 0->8 move -> all outputs 0 next cycle, Steps=0, no Done/Err; subsequent Start accepted normally.
